// File: rtl/ram_fifo_pkg.sv
// Shared sizing for the RAM-backed FIFO controller, the RAM and the benches.
// Latency: n/a (constants and a pointer helper only).
// Backpressure: n/a.
package ram_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    // Level reaches DEPTH+1 (RAM full plus the prefetched head word).
    localparam int CNT_W  = ADDR_W + 1;

    // Ring pointer advance; wraps DEPTH-1 -> 0 through natural overflow.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return p + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ram.sv
// 16x8 single-port synchronous RAM: write or registered read on each edge.
// Latency: write lands on the edge; read data appears one cycle after addr.
// Backpressure: none; one access per cycle, selected by rw.
module ram
    import ram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] indata,
    output logic [DATA_W-1:0] outdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single port: rw=1 stores indata, rw=0 registers the addressed word.
    always_ff @(posedge clk) begin
        if (rw) begin
            mem[addr] <= indata;
        end else begin
            outdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_fifo_top.sv
// Stream FIFO: ram_fifo_ctrl driving the single-port ram.
// Latency: 3 cycles from push into an empty FIFO to out_valid.
// Backpressure: in_ready low when full or when a read takes the port.
module ram_fifo_top
    import ram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_indata;
    logic [DATA_W-1:0] ram_outdata;

    ram_fifo_ctrl u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .ram_rw      (ram_rw),
        .ram_addr    (ram_addr),
        .ram_indata  (ram_indata),
        .ram_outdata (ram_outdata)
    );

    ram u_ram (
        .clk     (clk),
        .rw      (ram_rw),
        .addr    (ram_addr),
        .indata  (ram_indata),
        .outdata (ram_outdata)
    );

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller around a single-port RAM with a 1-word output register.
// Latency: empty-to-out_valid is 3 cycles (write, read issue, read data return).
// Backpressure: reads win the port over writes; in_ready drops when full or reading.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_indata,
    input  logic [DATA_W-1:0] ram_outdata
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ram_count_q, ram_count_d;
    logic              rd_pend_q, rd_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic rd_issue;
    logic wr_fire;

    // Port arbitration: a read is issued whenever the output register will have
    // room for its data; a write only gets the port on cycles with no read.
    always_comb begin
        rd_issue   = !rst && (ram_count_q != '0) && !rd_pend_q
                     && (!out_valid_q || out_ready);
        full       = (ram_count_q == CNT_W'(DEPTH));
        in_ready   = !rst && !full && !rd_issue;
        wr_fire    = in_valid && in_ready;
        ram_rw     = wr_fire;
        ram_indata = in_data;
        if (rst) begin
            ram_addr = '0;
        end else if (wr_fire) begin
            ram_addr = wr_ptr_q;
        end else begin
            ram_addr = rd_ptr_q;
        end
    end

    // Next-state: pointers/count follow the port access; the output register
    // loads returning read data, otherwise drains on a consumer pop.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        rd_pend_d   = rd_issue;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (wr_fire) begin
            wr_ptr_d    = ptr_inc(wr_ptr_q);
            ram_count_d = ram_count_q + CNT_W'(1);
        end
        if (rd_issue) begin
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            ram_count_d = ram_count_q - CNT_W'(1);
        end
        if (rd_pend_q) begin
            out_data_d  = ram_outdata;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset abandons whatever the RAM still holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Level counts every held word: in RAM, in flight from RAM, and at the output.
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
        level     = ram_count_q + CNT_W'(rd_pend_q) + CNT_W'(out_valid_q);
        empty     = (level == '0);
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl paired with the ram it drives; queue-based reference.
// Latency: checks the 3-cycle empty-to-output path and full/prefetch behaviour.
// Backpressure: random in_valid/out_ready exercise port arbitration.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_indata;
    logic [DATA_W-1:0] ram_outdata;

    ram_fifo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .ram_rw      (ram_rw),
        .ram_addr    (ram_addr),
        .ram_indata  (ram_indata),
        .ram_outdata (ram_outdata)
    );

    ram u_ram (
        .clk     (clk),
        .rw      (ram_rw),
        .addr    (ram_addr),
        .indata  (ram_indata),
        .outdata (ram_outdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: the FIFO contents in order, plus number of words accepted since reset.
    logic [DATA_W-1:0] model_q[$];
    int wr_cnt = 0;
    int pops = 0;
    bit synced = 0;
    logic [DATA_W-1:0] last_pop;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, update the reference.
    task automatic cyc(input logic r, input logic iv, input logic [DATA_W-1:0] id,
                       input logic ordy, output logic acc, output logic ov);
        int pre;
        @(negedge clk);
        rst = r; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        acc = 1'b0;
        ov  = out_valid;
        chk("indata_passthru", int'(ram_indata), int'(id));
        chk("no_write_when_full", int'(ram_rw && full), 0);
        if (synced) begin
            pre = model_q.size();
            chk("level", int'(level), pre);
            chk("empty", int'(empty), int'(pre == 0));
            chk("level_max", int'(level <= CNT_W'(DEPTH + 1)), 1);
            if (pre == DEPTH + 1) chk("in_ready_at_max", int'(in_ready), 0);
        end
        if (r) begin
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_rw", int'(ram_rw), 0);
            chk("rst_addr", int'(ram_addr), 0);
            model_q.delete();
            wr_cnt = 0;
            synced = 1;
        end else begin
            acc = in_valid && in_ready;
            chk("rw_on_accept", int'(ram_rw), int'(acc));
            if (out_valid && out_ready) begin
                if (model_q.size() == 0) begin
                    chk("pop_from_empty", 1, 0);
                end else begin
                    last_pop = model_q.pop_front();
                    chk("out_data_order", int'(out_data), int'(last_pop));
                end
                pops++;
            end
            if (acc) begin
                chk("wr_addr", int'(ram_addr), wr_cnt % DEPTH);
                wr_cnt++;
                model_q.push_back(id);
            end
        end
    endtask

    initial begin
        logic acc, ov;
        int k, budget, sent;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset, then idle.
        cyc(1, 0, 8'h00, 0, acc, ov);
        cyc(1, 1, 8'h11, 1, acc, ov);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 0, acc, ov);
            chk("idle_level", int'(level), 0);
            chk("idle_empty", int'(empty), 1);
            chk("idle_full", int'(full), 0);
            chk("idle_out_valid", int'(out_valid), 0);
            chk("idle_rw", int'(ram_rw), 0);
        end

        // Single word latency.
        cyc(0, 1, 8'hA5, 1, acc, ov);
        chk("a5_accept", int'(acc), 1);
        chk("a5_rw", int'(ram_rw), 1);
        chk("a5_addr", int'(ram_addr), 0);
        cyc(0, 0, 8'h00, 1, acc, ov);
        chk("a5_c1_valid", int'(ov), 0);
        cyc(0, 0, 8'h00, 1, acc, ov);
        chk("a5_c2_valid", int'(ov), 0);
        cyc(0, 0, 8'h00, 1, acc, ov);
        chk("a5_c3_valid", int'(ov), 1);
        chk("a5_c3_data", int'(out_data), 8'hA5);
        cyc(0, 0, 8'h00, 1, acc, ov);
        chk("a5_level_back", int'(level), 0);

        // Fill to DEPTH+1 with out_ready low.
        k = 0;
        budget = 200;
        while (k < DEPTH + 1 && budget > 0) begin
            cyc(0, 1, 8'(k), 0, acc, ov);
            if (acc) k++;
            budget--;
        end
        chk("fill_budget", int'(k), DEPTH + 1);
        cyc(0, 1, 8'hEE, 0, acc, ov);
        chk("fill_level", int'(level), DEPTH + 1);
        chk("fill_full", int'(full), 1);
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_no_accept", int'(acc), 0);

        // Drain in order.
        pops = 0;
        budget = 200;
        while (model_q.size() > 0 && budget > 0) begin
            cyc(0, 0, 8'h00, 1, acc, ov);
            budget--;
        end
        chk("drain_count", pops, DEPTH + 1);
        chk("drain_last", int'(last_pop), 8'h10);
        cyc(0, 0, 8'h00, 1, acc, ov);
        chk("drain_empty", int'(empty), 1);

        // Random traffic.
        sent = 0;
        budget = 30000;
        while ((sent < 1000 || model_q.size() > 0) && budget > 0) begin
            cyc(0, logic'(sent < 1000 && $urandom_range(1, 0) == 1),
                8'($urandom_range(255, 0)), logic'($urandom_range(1, 0)), acc, ov);
            if (acc) sent++;
            budget--;
        end
        chk("rand_sent", sent, 1000);
        chk("rand_drained", model_q.size(), 0);

        // Mid-stream reset at level 9.
        budget = 200;
        k = 0;
        while (model_q.size() < 9 && budget > 0) begin
            cyc(0, 1, 8'(8'h80 + k), 0, acc, ov);
            if (acc) k++;
            budget--;
        end
        chk("pre_rst_fill", model_q.size(), 9);
        cyc(1, 0, 8'h00, 0, acc, ov);
        cyc(0, 0, 8'h00, 0, acc, ov);
        chk("post_rst_level", int'(level), 0);
        chk("post_rst_empty", int'(empty), 1);
        chk("post_rst_full", int'(full), 0);
        chk("post_rst_valid", int'(out_valid), 0);
        chk("post_rst_data", int'(out_data), 0);
        acc = 1'b0;
        budget = 20;
        while (!acc && budget > 0) begin
            cyc(0, 1, 8'h3C, 1, acc, ov);
            budget--;
        end
        chk("3c_accept", int'(acc), 1);
        chk("3c_addr_zero_after_rst", wr_cnt, 1);
        pops = 0;
        budget = 20;
        while (model_q.size() > 0 && budget > 0) begin
            cyc(0, 0, 8'h00, 1, acc, ov);
            budget--;
        end
        chk("3c_pops", pops, 1);
        chk("3c_data", int'(last_pop), 8'h3C);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'h00, 1, acc, ov);
            chk("3c_no_stale", int'(out_valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
